// File: rtl/temporal_mxu_gen.sv
// rtl/temporal_mxu_gen.sv - Temporal-unary matrix multiplier C = A x B with valid/ready result hold
//
// Purpose:
//   Multiplies unsigned matrix A (M x K) by unsigned matrix B (K x N). Each A
//   element is treated as a unary pulse train: in compute cycle c, B[k][j] is
//   added into acc[i][j] whenever c < A[i][k]. After L cycles every acc holds
//   the exact dot product. L is 2^BIT_WIDTH-1 or, with EARLY_EXIT, the largest
//   registered A element.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin a multiply (only honoured in IDLE)
//   A, B       operand matrices, captured together with start
//   busy       high while computing or holding a result
//   out        result matrix, converted to OUT_W bits (wrap or saturate)
//   out_valid  result available; held until out_ready
//   out_ready  consumer accepts the result
//   overflow   some element did not fit in OUT_W bits (qualified by out_valid)

module temporal_mxu_gen #(
    parameter int BIT_WIDTH  = 4,
    parameter int M          = 2,
    parameter int K          = 2,
    parameter int N          = 2,
    parameter int OUT_W      = 2 * BIT_WIDTH,
    parameter int SATURATE   = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]   A,
    input  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]   B,
    output logic                                 busy,
    output logic [M-1:0][N-1:0][OUT_W-1:0]       out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overflow
);

    localparam int ACC_W = 2 * BIT_WIDTH + $clog2(K);
    // One spare bit above the wider of acc/out so the range compare never wraps.
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic [CMP_W-1:0] OUT_MAX = {{(CMP_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

    state_t state;
    state_t state_next;

    logic [M-1:0][K-1:0][BIT_WIDTH-1:0] a_reg;
    logic [K-1:0][N-1:0][BIT_WIDTH-1:0] b_reg;
    logic [M-1:0][N-1:0][ACC_W-1:0]     acc;
    logic [M-1:0][N-1:0][ACC_W-1:0]     acc_next;
    logic [BIT_WIDTH-1:0]               c;
    logic [BIT_WIDTH-1:0]               len_reg;
    logic [BIT_WIDTH-1:0]               max_a;
    logic [BIT_WIDTH-1:0]               len_start;
    logic [M-1:0][N-1:0][OUT_W-1:0]     conv;
    logic [M*N-1:0]                     exceed;

    assign busy = (state != IDLE);

    // Compute length is decided from the live A input on the start edge, the
    // same values that get registered, so L=0 can skip COMPUTE entirely.
    always_comb begin
        max_a = '0;
        for (int i = 0; i < M; i++) begin
            for (int k = 0; k < K; k++) begin
                if (A[i][k] > max_a) max_a = A[i][k];
            end
        end
        len_start = (EARLY_EXIT != 0) ? max_a : {BIT_WIDTH{1'b1}};
    end

    // Unary-in-time A gates binary B into each accumulator.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < K; k++) begin
                    if (c < a_reg[i][k]) begin
                        acc_next[i][j] = acc_next[i][j] + ACC_W'(b_reg[k][j]);
                    end
                end
            end
        end
    end

    always_comb begin
        conv   = '0;
        exceed = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                exceed[i*N+j] = (CMP_W'(acc[i][j]) > OUT_MAX);
                conv[i][j]    = (exceed[i*N+j] && (SATURATE != 0)) ? {OUT_W{1'b1}}
                                                                   : OUT_W'(CMP_W'(acc[i][j]));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len_start == '0) ? HOLD : COMPUTE;
            COMPUTE: if (c == len_reg - BIT_WIDTH'(1)) state_next = HOLD;
            HOLD:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // out_valid rises one edge after entering HOLD; that edge also latches the
    // converted result so the conversion logic sits off the accumulate path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            c         <= '0;
            len_reg   <= '0;
            out       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= A;
                        b_reg   <= B;
                        acc     <= '0;
                        c       <= '0;
                        len_reg <= len_start;
                    end
                end
                COMPUTE: begin
                    acc <= acc_next;
                    c   <= c + BIT_WIDTH'(1);
                end
                HOLD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out       <= conv;
                        overflow  <= |exceed;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_temporal_mxu_gen.sv
// tb/tb_temporal_mxu_gen.sv - Directed-vector bench for temporal_mxu_gen
module tb_temporal_mxu_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start0, start_e, out_ready;
    logic [1:0][1:0][3:0] A, B;

    logic busy0, vld0, ov0;
    logic [1:0][1:0][7:0] out0;
    logic busy1, vld1, ov1;
    logic [1:0][1:0][7:0] out1;
    logic busy2, vld2, ov2;
    logic [1:0][1:0][8:0] out2;
    logic busy3, vld3, ov3;
    logic [1:0][1:0][7:0] out3;

    int n_vec = 0;
    int n_err = 0;

    temporal_mxu_gen #(.BIT_WIDTH(4), .M(2), .K(2), .N(2), .OUT_W(8), .SATURATE(0), .EARLY_EXIT(0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start0), .A(A), .B(B), .busy(busy0),
        .out(out0), .out_valid(vld0), .out_ready(out_ready), .overflow(ov0));

    temporal_mxu_gen #(.BIT_WIDTH(4), .M(2), .K(2), .N(2), .OUT_W(8), .SATURATE(1), .EARLY_EXIT(0)) dut_sat (
        .clk(clk), .reset(reset), .start(start0), .A(A), .B(B), .busy(busy1),
        .out(out1), .out_valid(vld1), .out_ready(out_ready), .overflow(ov1));

    temporal_mxu_gen #(.BIT_WIDTH(4), .M(2), .K(2), .N(2), .OUT_W(9), .SATURATE(0), .EARLY_EXIT(0)) dut_w9 (
        .clk(clk), .reset(reset), .start(start0), .A(A), .B(B), .busy(busy2),
        .out(out2), .out_valid(vld2), .out_ready(out_ready), .overflow(ov2));

    temporal_mxu_gen #(.BIT_WIDTH(4), .M(2), .K(2), .N(2), .OUT_W(8), .SATURATE(0), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .reset(reset), .start(start_e), .A(A), .B(B), .busy(busy3),
        .out(out3), .out_valid(vld3), .out_ready(out_ready), .overflow(ov3));

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_mat(input string tag, input int g00, input int g01, input int g10, input int g11,
                             input int e00, input int e01, input int e10, input int e11);
        check_vec({tag, "[0][0]"}, g00, e00);
        check_vec({tag, "[0][1]"}, g01, e01);
        check_vec({tag, "[1][0]"}, g10, e10);
        check_vec({tag, "[1][1]"}, g11, e11);
    endtask

    task automatic set_ab(input int a00, input int a01, input int a10, input int a11,
                          input int b00, input int b01, input int b10, input int b11);
        A[0][0] = 4'(a00); A[0][1] = 4'(a01); A[1][0] = 4'(a10); A[1][1] = 4'(a11);
        B[0][0] = 4'(b00); B[0][1] = 4'(b01); B[1][0] = 4'(b10); B[1][1] = 4'(b11);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start_e = 1'b0; out_ready = 1'b0;
        set_ab(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        check_vec("rst_busy", busy0, 0);
        check_vec("rst_valid", vld0, 0);
        check_vec("rst_ovf", ov0, 0);
        check_mat("rst_out", out0[0][0], out0[0][1], out0[1][0], out0[1][1], 0, 0, 0, 0);

        // Run 1: reference multiply, start on first edge after reset release.
        reset = 1'b0;
        out_ready = 1'b1;
        set_ab(2, 8, 12, 14, 6, 12, 12, 9);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        set_ab(15, 15, 15, 15, 15, 15, 15, 15);
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 1)  check_vec("r1_busy_e1", busy0, 1);
            if (e == 15) check_vec("r1_valid_e15", vld0, 0);
        end
        check_vec("r1_valid_e16", vld0, 1);
        check_mat("r1_wrap", out0[0][0], out0[0][1], out0[1][0], out0[1][1], 108, 96, 240, 14);
        check_vec("r1_wrap_ovf", ov0, 1);
        check_mat("r1_sat", out1[0][0], out1[0][1], out1[1][0], out1[1][1], 108, 96, 240, 255);
        check_vec("r1_sat_ovf", ov1, 1);
        check_mat("r1_w9", out2[0][0], out2[0][1], out2[1][0], out2[1][1], 108, 96, 240, 270);
        check_vec("r1_w9_ovf", ov2, 0);
        tick();
        check_vec("r1_hs_valid", vld0, 0);
        check_vec("r1_hs_busy", busy0, 0);
        check_vec("r1_retain", out0[1][0], 240);

        // Run 2: consumer stalls; stray start mid-compute with new A.
        out_ready = 1'b0;
        set_ab(3, 0, 5, 7, 2, 4, 6, 1);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 5) begin
                start0 = 1'b1;
                set_ab(15, 15, 15, 15, 15, 15, 15, 15);
            end else begin
                start0 = 1'b0;
            end
        end
        check_vec("r2_valid", vld0, 1);
        check_mat("r2_out", out0[0][0], out0[0][1], out0[1][0], out0[1][1], 6, 12, 52, 27);
        check_vec("r2_ovf", ov0, 0);
        for (int h = 0; h < 5; h++) begin
            tick();
            check_vec("r2_hold_valid", vld0, 1);
            check_vec("r2_hold_out", out0[1][1], 27);
        end

        // Handshake with start already high: ignored on that edge, taken next.
        out_ready = 1'b1;
        set_ab(1, 1, 1, 1, 1, 2, 3, 4);
        start0 = 1'b1;
        tick();
        check_vec("r2_hs_valid", vld0, 0);
        check_vec("r2_hs_busy", busy0, 0);
        tick();
        check_vec("b2b_busy", busy0, 1);
        start0 = 1'b0;
        for (int e = 0; e < 5; e++) tick();

        // Asynchronous reset mid-compute.
        reset = 1'b1;
        #1;
        check_vec("mid_rst_busy", busy0, 0);
        check_vec("mid_rst_valid", vld0, 0);
        check_vec("mid_rst_ovf", ov0, 0);
        check_mat("mid_rst_out", out0[0][0], out0[0][1], out0[1][0], out0[1][1], 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        set_ab(2, 8, 12, 14, 6, 12, 12, 9);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int e = 1; e <= 16; e++) tick();
        check_vec("post_rst_valid", vld0, 1);
        check_mat("post_rst_out", out0[0][0], out0[0][1], out0[1][0], out0[1][1], 108, 96, 240, 14);
        check_vec("post_rst_ovf", ov0, 1);
        tick();
        check_vec("post_rst_hs", vld0, 0);

        // Early exit, L = 1.
        set_ab(1, 0, 0, 1, 3, 5, 7, 9);
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        tick();
        check_vec("ee1_valid_e1", vld3, 0);
        check_vec("ee1_busy_e1", busy3, 1);
        tick();
        check_vec("ee1_valid_e2", vld3, 1);
        check_mat("ee1_out", out3[0][0], out3[0][1], out3[1][0], out3[1][1], 3, 5, 7, 9);
        check_vec("ee1_ovf", ov3, 0);
        tick();
        check_vec("ee1_hs", vld3, 0);

        // Early exit, L = 0.
        set_ab(0, 0, 0, 0, 9, 9, 9, 9);
        start_e = 1'b1;
        tick();
        start_e = 1'b0;
        check_vec("ee0_busy_e0", busy3, 1);
        check_vec("ee0_valid_e0", vld3, 0);
        tick();
        check_vec("ee0_valid_e1", vld3, 1);
        check_mat("ee0_out", out3[0][0], out3[0][1], out3[1][0], out3[1][1], 0, 0, 0, 0);
        check_vec("ee0_ovf", ov3, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
